prog_rom_arbiter: RTL
=====================

Name: prog_rom_arbiter

Overview:
- Shares a single-port 40 KB program RAM (five 8 KB images: 1F, 1H, 1K, 1L, 1N) between the 6502 fetch path and the HPS ioctl download path.
- Decodes the CPU chip selects and the bank select into a linear RAM address.
- Buffers download bytes in a one-entry holding register and back-pressures the HPS.
- Holds the CPU in reset while a download is in progress.
- Sits between the CPU bus decode and the program RAM primitive.

Parameters:
- IMG_AW, 13, address width of one ROM image (8 KB).
- N_IMG, 5, number of ROM images in the RAM.
- RAM_AW, 16, RAM address width; must satisfy 2^RAM_AW >= N_IMG*2^IMG_AW.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  one-cycle strobe: CPU read cycle starts; address and selects are valid
- address  in  13  CPU address within image
- ROM0n, ROM1n, ROM2n  in  1 each  active-low image-group selects
- BANK0n  in  1  active-low bank select
- cpu_data  out  8  read data
- cpu_valid  out  1  one-cycle strobe: cpu_data valid
- ioctl_download  in  1  download session active
- ioctl_wr  in  1  one-cycle write strobe
- ioctl_addr  in  16  linear byte address of the download
- ioctl_dout  in  8  download byte
- ioctl_wait  out  1  back-pressure to HPS
- cpu_hold  out  1  CPU reset request
- ram_addr  out  RAM_AW  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data, registered, 1-cycle latency

Behaviour:
- Reset values: cpu_data=0, cpu_valid=0, ioctl_wait=0, cpu_hold=1, ram_we=0, ram_addr=0, ram_din=0. State goes to IDLE and the holding register is emptied.
- Image index decode (priority order):
  - ~ROM1n: 3 when ~BANK0n, else 0 (1L/1F).
  - else ~ROM0n: 2 when ~BANK0n, else 1 (1K/1H).
  - else: 4 (1N, default).
- CPU address: ram_addr = {idx, address}.
- States:
  - IDLE:
    - cpu_req and not cpu_hold → RD. Drive ram_addr from the CPU address; ram_we=0.
    - else holding register full → WR. Drive ram_addr/ram_din from the holder; ram_we=1 for exactly one cycle.
  - RD: capture ram_dout into cpu_data, pulse cpu_valid, → IDLE. CPU read latency is 2 cycles from cpu_req to cpu_valid.
  - WR: clear the holding register, → IDLE.
- Priority: CPU read beats a pending write in the same cycle. While cpu_hold=1, no CPU reads are granted, so writes always drain.
- Holding register:
  - ioctl_wr while empty → load addr/data and set full.
  - ioctl_wait = full.
  - ioctl_wr while full is a protocol violation: drop the byte and set a sticky internal overrun flag (cleared by reset), visible to the bench via hierarchical probe.
- Address range: writes with ioctl_addr >= N_IMG*8192 are accepted and discarded. The holder clears without a RAM write.
- cpu_hold:
  - Set on reset.
  - Set on the rising edge of ioctl_download.
  - Cleared 2 cycles after ioctl_download falls and the holder is empty. Those 2 cycles guarantee the last write has committed.
- cpu_req while in RD/WR: latched into a one-bit pending flag and served on the next IDLE. The CPU never loses a read. A second cpu_req while the flag is set is not supported; the bench asserts it never occurs.
- Reset mid-operation: an in-flight RD produces no cpu_valid. An in-flight WR still completes the current ram_we cycle, because reset is sampled at the same edge; the holder clears.

Decomposition:
- Package prog_rom_pkg holds:
  - image index constants IMG_1F=0, IMG_1H=1, IMG_1K=2, IMG_1L=3, IMG_1N=4;
  - the state enum IDLE/RD/WR;
  - IMG_BYTES=8192.
- One natural sub-module, rom_select_decode: a combinational index decode from ROM0n/ROM1n/BANK0n. It is reused by the debug overlay.

Test Plan:
- Reset, then release with ioctl_download=0 → cpu_hold stays 1 until reset falls +2 cycles; all outputs 0.
- Download 0xA5 to ioctl_addr 0x6000 (image 3, offset 0) → ram_we pulse with ram_addr=0x6000 and ram_din=0xA5; ioctl_wait high for exactly 1–2 cycles.
- After the download ends, cpu_req with ROM1n=0, BANK0n=0, address=0 → cpu_valid 2 cycles later with cpu_data=0xA5. Repeat with BANK0n=1 → ram_addr=0x0000.
- Two back-to-back ioctl_wr (second while ioctl_wait=1) → second byte dropped, overrun flag set, RAM holds only the first byte.
- Write to ioctl_addr 0xA000 → no ram_we; holder clears; cpu_hold releases normally.
- cpu_req arriving in the WR cycle → served next IDLE; cpu_valid 3 cycles after cpu_req with correct data for idx 4 (all selects high).

Source files
------------

// File: rtl/prog_rom_pkg.sv
// Shared constants for the program ROM arbiter: image indices, image size and FSM states.
package prog_rom_pkg;

  localparam logic [2:0] IMG_1F = 3'd0;
  localparam logic [2:0] IMG_1H = 3'd1;
  localparam logic [2:0] IMG_1K = 3'd2;
  localparam logic [2:0] IMG_1L = 3'd3;
  localparam logic [2:0] IMG_1N = 3'd4;

  localparam int unsigned IMG_BYTES = 8192;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

endpackage

// File: rtl/prog_rom_arbiter_decode.sv
// Maps the CPU image-group selects and bank select to a ROM image index.
module rom_select_decode
  import prog_rom_pkg::*;
(
  input  logic       ROM0n,
  input  logic       ROM1n,
  input  logic       BANK0n,
  output logic [2:0] idx
);

  // ROM1n outranks ROM0n; with neither asserted the 1N image is selected.
  always_comb begin
    if (!ROM1n) begin
      idx = BANK0n ? IMG_1F : IMG_1L;
    end else if (!ROM0n) begin
      idx = BANK0n ? IMG_1H : IMG_1K;
    end else begin
      idx = IMG_1N;
    end
  end

endmodule

// File: rtl/prog_rom_arbiter.sv
// Arbitrates the single-port program RAM between 6502 fetches and HPS ioctl downloads.
// Valid/ready: cpu_req and ioctl_wr are one-cycle strobes; ioctl_wait high means the next ioctl_wr is dropped.
module prog_rom_arbiter
  import prog_rom_pkg::*;
#(
  parameter int IMG_AW = 13,
  parameter int N_IMG  = 5,
  parameter int RAM_AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [IMG_AW-1:0] address,
  input  logic              ROM0n,
  input  logic              ROM1n,
  input  logic              ROM2n,
  input  logic              BANK0n,
  output logic [7:0]        cpu_data,
  output logic              cpu_valid,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [15:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              cpu_hold,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  localparam int unsigned RAM_BYTES = N_IMG * IMG_BYTES;

  state_t              state;
  state_t              state_nxt;
  logic                grant;
  logic [2:0]          cur_idx;
  logic [RAM_AW-1:0]   cpu_lin;
  logic                pend;
  logic [RAM_AW-1:0]   pend_addr;
  logic                hold_full;
  logic [15:0]         hold_addr;
  logic [7:0]          hold_data;
  logic                in_range;
  logic                overrun;
  logic                dl_q;
  logic                rel_armed;
  logic                rom2_unused;

  // ROM2n selects no image in this memory map.
  assign rom2_unused = ROM2n;

  rom_select_decode u_decode (
    .ROM0n  (ROM0n),
    .ROM1n  (ROM1n),
    .BANK0n (BANK0n),
    .idx    (cur_idx)
  );

  assign cpu_lin    = RAM_AW'({cur_idx, address});
  assign in_range   = ({16'd0, hold_addr} < RAM_BYTES);
  assign ioctl_wait = hold_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A CPU read wins over a queued download byte; reads are never granted while the CPU is held.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if ((cpu_req || pend) && !cpu_hold) begin
          grant     = 1'b1;
          state_nxt = RD;
        end else if (hold_full) begin
          state_nxt = WR;
        end
      end
      RD:      state_nxt = IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port is combinational from the registered state so a WR cycle under reset still commits.
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (grant) begin
      ram_addr = pend ? pend_addr : cpu_lin;
    end else if (state == WR) begin
      ram_addr = RAM_AW'(hold_addr);
      ram_we   = in_range;
      ram_din  = hold_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_addr <= '0;
    end else if (grant) begin
      pend <= 1'b0;
    end else if (cpu_req && state != IDLE) begin
      pend      <= 1'b1;
      pend_addr <= cpu_lin;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_data  <= '0;
      cpu_valid <= 1'b0;
    end else begin
      cpu_valid <= (state == RD);
      if (state == RD) begin
        cpu_data <= ram_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      overrun   <= 1'b0;
    end else begin
      if (state == WR) begin
        hold_full <= 1'b0;
      end
      if (ioctl_wr) begin
        if (!hold_full) begin
          hold_full <= 1'b1;
          hold_addr <= ioctl_addr;
          hold_data <= ioctl_dout;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Release needs two consecutive quiet cycles so the final download byte has reached the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_hold  <= 1'b1;
      rel_armed <= 1'b0;
      dl_q      <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (ioctl_download && !dl_q) begin
        cpu_hold  <= 1'b1;
        rel_armed <= 1'b0;
      end else if (ioctl_download || hold_full) begin
        rel_armed <= 1'b0;
      end else if (cpu_hold) begin
        if (rel_armed) begin
          cpu_hold <= 1'b0;
        end else begin
          rel_armed <= 1'b1;
        end
      end
    end
  end

endmodule
